// File: rtl/apb_pkg.sv
// Shared types and widths for the APB completer memory.
// Build option APB_SLV_ERR_EN (see apb_slave_mem) does not affect this package.
package apb_pkg;

   localparam int APB_DW = 32;
   localparam int APB_AW = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_slv_state_e;

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x 32 register memory: one synchronous write port and one registered read port.
// The read register doubles as the bus read-data output, so it has its own clear.
module apb_slv_regfile
   import apb_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [APB_DW-1:0] wdata,
   input  logic              re,
   input  logic              clr,
   input  logic [AW-1:0]     raddr,
   output logic [APB_DW-1:0] rdata
);

   logic [APB_DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[waddr] <= wdata;
         end
         // Clear wins so the read data drops to zero on the completion edge.
         if (clr) begin
            rdata <= '0;
         end else if (re) begin
            rdata <= mem[raddr];
         end
      end
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: word-addressed register memory with programmable wait states.
// Define APB_SLV_ERR_EN to answer misaligned/out-of-window accesses with PSLVERR.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int                DEPTH     = 16,
   parameter logic [APB_AW-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int                WAIT_W    = 4
) (
   input  logic              clk,
   input  logic              PRESET,
   input  logic              PSEL1,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [APB_AW-1:0] PADDR,
   input  logic [APB_DW-1:0] PWDATA,
   input  logic [WAIT_W-1:0] wait_cfg,
   output logic [APB_DW-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output apb_slv_state_e    fsm_state
);

   localparam int AW = $clog2(DEPTH);

   apb_slv_state_e    state;
   logic [WAIT_W-1:0] cnt;
   logic [AW-1:0]     idx_q;
   logic              write_q;
   logic [APB_DW-1:0] wdata_q;
   logic              err_q;

   logic [APB_AW-1:0] live_off;
   logic [AW-1:0]     live_idx;
   logic              live_err;
   logic              setup;
   logic              unused_off;

   // The address is decoded at setup and only the word index and error flag are
   // kept, so later changes on PADDR cannot affect the transfer.
   assign live_off   = PADDR - BASE_ADDR;
   assign live_idx   = live_off[AW+1:2];
   assign unused_off = ^{live_off[APB_AW-1:AW+2], live_off[1:0]};
   assign setup      = PSEL1 && !PENABLE;

`ifdef APB_SLV_ERR_EN
   localparam logic [APB_AW:0] END_ADDR = {1'b0, BASE_ADDR} + (APB_AW+1)'(DEPTH * 4);

   assign live_err = (PADDR[1:0] != 2'b00) || (PADDR < BASE_ADDR) ||
                     ({1'b0, PADDR} >= END_ADDR);
`else
   assign live_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (PRESET) begin
         state   <= IDLE;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         cnt     <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (setup) begin
                  state   <= ACCESS;
                  idx_q   <= live_idx;
                  write_q <= PWRITE;
                  wdata_q <= PWDATA;
                  err_q   <= live_err;
                  cnt     <= wait_cfg;
                  PREADY  <= (wait_cfg == '0);
                  PSLVERR <= (wait_cfg == '0) && live_err;
               end
            end
            ACCESS: begin
               if (!PSEL1) begin
                  state   <= IDLE;
                  PREADY  <= 1'b0;
                  PSLVERR <= 1'b0;
               end else if (!PREADY) begin
                  cnt     <= cnt - WAIT_W'(1);
                  PREADY  <= (cnt == WAIT_W'(1));
                  PSLVERR <= (cnt == WAIT_W'(1)) && err_q;
               end else if (PENABLE) begin
                  state   <= IDLE;
                  PREADY  <= 1'b0;
                  PSLVERR <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   logic              rf_we;
   logic              rf_re;
   logic              rf_clr;
   logic [AW-1:0]     rf_raddr;

   // Read data is captured on exactly the edge that raises PREADY.
   always_comb begin
      rf_we    = 1'b0;
      rf_re    = 1'b0;
      rf_clr   = 1'b0;
      rf_raddr = idx_q;
      case (state)
         IDLE: begin
            rf_raddr = live_idx;
            rf_re    = setup && !PWRITE && (wait_cfg == '0) && !live_err;
         end
         ACCESS: begin
            if (!PSEL1) begin
               rf_clr = 1'b1;
            end else if (!PREADY) begin
               rf_re = (cnt == WAIT_W'(1)) && !write_q && !err_q;
            end else if (PENABLE) begin
               rf_clr = 1'b1;
               rf_we  = write_q && !err_q;
            end
         end
         default: begin
            rf_clr = 1'b1;
         end
      endcase
   end

   apb_slv_regfile #(
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk   (clk),
      .rst   (PRESET),
      .we    (rf_we),
      .waddr (idx_q),
      .wdata (wdata_q),
      .re    (rf_re),
      .clr   (rf_clr),
      .raddr (rf_raddr),
      .rdata (PRDATA)
   );

   assign fsm_state = state;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: transaction-level memory model, per-cycle compare
// against it, and literal read-data expectations. Honours APB_SLV_ERR_EN like the DUT.
module tb_apb_slave_mem;
   import apb_pkg::*;

   localparam int          DEPTH  = 16;
   localparam logic [31:0] BASE   = 32'h0000_1000;
   localparam int          WAIT_W = 4;

   logic        clk = 1'b0;
   logic        PRESET = 1'b1;
   logic        PSEL1 = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [31:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [WAIT_W-1:0] wait_cfg = '0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   apb_slv_state_e fsm_state;

   apb_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_W(WAIT_W)) dut (
      .clk(clk), .PRESET(PRESET), .PSEL1(PSEL1), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .wait_cfg(wait_cfg),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- model and scoreboard state ----------------
   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_q[$];
   logic        exp_ready = 1'b0;
   logic        exp_err = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic        exp_busy = 1'b0;
   bit          chk_en = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

`ifdef APB_SLV_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   function automatic bit model_err(input logic [31:0] a);
      if (!ERR_EN) return 1'b0;
      return (a % 4 != 0) || (a < BASE) || (a >= BASE + DEPTH * 4);
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      logic [31:0] w;
      w = (a - BASE) / 4;
      return int'(w % DEPTH);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
   endtask

   task automatic exp_idle();
      exp_busy  = 1'b0;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = '0;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("pready",  {31'b0, PREADY},  {31'b0, exp_ready});
         check("pslverr", {31'b0, PSLVERR}, {31'b0, exp_err});
         check("prdata",  PRDATA,           exp_rdata);
         check("busy",    {31'b0, (fsm_state == ACCESS)}, {31'b0, exp_busy});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      PSEL1   = 1'b0;
      PENABLE = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // One transfer. drop_at>0 releases PSEL1 after that many ACCESS cycles.
   // lit=1 pops a hand-computed read value from exp_q at the ready cycle.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int wt, input int drop_at, input bit lit);
      bit e;
      int idx;
      logic [31:0] lv;
      e   = model_err(addr);
      idx = model_idx(addr);
      PSEL1    = 1'b1;
      PENABLE  = 1'b0;
      PWRITE   = wr;
      PADDR    = addr;
      PWDATA   = data;
      wait_cfg = WAIT_W'(wt);
      @(posedge clk); #1;
      PENABLE  = 1'b1;
      PADDR    = addr ^ 32'h0000_0034;
      PWDATA   = ~data;
      wait_cfg = WAIT_W'(wt + 7);
      for (int k = 1; k <= wt + 1; k++) begin
         exp_busy  = 1'b1;
         exp_ready = (k == wt + 1);
         exp_err   = exp_ready && e;
         exp_rdata = (exp_ready && !wr && !e) ? model_mem[idx] : 32'h0;
         if (drop_at > 0 && k == drop_at + 1) begin
            PSEL1   = 1'b0;
            PENABLE = 1'b0;
            @(posedge clk); #1;
            exp_idle();
            check("abort_idle", {31'b0, (fsm_state == ACCESS)}, 32'h0);
            return;
         end
         if (exp_ready && lit) begin
            if (exp_q.size() == 0) begin
               check("exp_q_empty", 32'h1, 32'h0);
            end else begin
               lv = exp_q.pop_front();
               check("read_literal", PRDATA, lv);
            end
         end
         @(posedge clk); #1;
      end
      if (wr && !e) model_mem[idx] = data;
      exp_idle();
      PSEL1   = 1'b0;
      PENABLE = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_clear();
      PRESET = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      PRESET = 1'b0;
      idle(1);

      // Basic write then read, zero waits.
      xfer(1'b1, BASE + 8, 32'hDEADBEEF, 0, 0, 1'b0);
      idle(1);
      exp_q.push_back(32'hDEADBEEF);
      xfer(1'b0, BASE + 8, 32'h0, 0, 0, 1'b1);
      idle(1);

      // Read with three wait states.
      exp_q.push_back(32'hDEADBEEF);
      xfer(1'b0, BASE + 8, 32'h0, 3, 0, 1'b1);
      idle(1);

      // One word past the window: error or alias onto word 0.
      xfer(1'b1, BASE + DEPTH * 4, 32'h0000_1234, 0, 0, 1'b0);
      idle(1);
      exp_q.push_back(ERR_EN ? 32'h0 : 32'h0000_1234);
      xfer(1'b0, BASE, 32'h0, 0, 0, 1'b1);
      idle(1);

      // Misaligned read, and a read just below the window aliasing the last word.
      exp_q.push_back(ERR_EN ? 32'h0 : 32'hDEADBEEF);
      xfer(1'b0, BASE + 9, 32'h0, 1, 0, 1'b1);
      xfer(1'b1, BASE + 60, 32'h0F0F_0F0F, 2, 0, 1'b0);
      exp_q.push_back(ERR_EN ? 32'h0 : 32'h0F0F_0F0F);
      xfer(1'b0, BASE - 4, 32'h0, 0, 0, 1'b1);
      idle(1);

      // Back-to-back write/read, PSEL1 never drops between them.
      xfer(1'b1, BASE + 4, 32'hA5A5A5A5, 0, 0, 1'b0);
      exp_q.push_back(32'hA5A5A5A5);
      xfer(1'b0, BASE + 4, 32'h0, 0, 0, 1'b1);
      idle(1);

      // PENABLE without setup is ignored.
      PSEL1 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = BASE; PWDATA = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      idle(1);

      // Aborted write: initiator drops PSEL1 mid-wait.
      xfer(1'b1, BASE + 12, 32'h5555_5555, 5, 2, 1'b0);
      idle(1);
      exp_q.push_back(32'h0);
      xfer(1'b0, BASE + 12, 32'h0, 0, 0, 1'b1);
      idle(1);

      // Table of back-to-back writes with assorted waits, then read-back.
      for (int i = 0; i < 6; i++) begin
         xfer(1'b1, BASE + 32 + 4 * i, 32'h1111_1111 * (i + 1), i % 4, 0, 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(32'h1111_1111 * (i + 1));
         xfer(1'b0, BASE + 32 + 4 * i, 32'h0, (i + 1) % 4, 0, 1'b1);
      end
      idle(1);

      // Reset in the middle of a four-wait read.
      PSEL1 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = BASE + 8; wait_cfg = 4'd4;
      @(posedge clk); #1;
      exp_busy = 1'b1;
      PENABLE  = 1'b1;
      @(posedge clk); #1;
      PRESET = 1'b1;
      @(posedge clk); #1;
      PRESET  = 1'b0;
      PSEL1   = 1'b0;
      PENABLE = 1'b0;
      exp_idle();
      model_clear();
      check("rst_pready", {31'b0, PREADY}, 32'h0);
      check("rst_prdata", PRDATA, 32'h0);
      idle(1);
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(32'h0);
         xfer(1'b0, BASE + 4 * i, 32'h0, 0, 0, 1'b1);
      end
      idle(2);

      if (exp_q.size() != 0) check("exp_q_left", exp_q.size(), 32'h0);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
